// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared defines: divider FSM states and DIV/DIVU alucontrol codes
package div_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // alucontrol encodings decoded into startE/signed_divE by the Execute stage
  localparam logic [3:0] ALUCTRL_DIV  = 4'b1010;
  localparam logic [3:0] ALUCTRL_DIVU = 4'b1011;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative restoring divider, fixed WIDTH+1 cycle latency
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   src_aE,
  input  logic [WIDTH-1:0]   src_bE,
  input  logic               signed_divE,
  input  logic               startE,
  input  logic               flushE,
  output logic               div_stallE,
  output logic               div_readyE,
  output logic [2*WIDTH-1:0] div_resultE
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t state_q, state_d;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] rem;
  logic [WIDTH-1:0]   divisor_abs;
  logic               signed_q, a_sign_q, b_sign_q;

  logic               accept, by_zero, last_step;
  logic               stall_c, ready_c;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH:0]   partial;
  logic [WIDTH:0]     upper;
  logic [WIDTH-1:0]   diff;
  logic               fits;
  logic [2*WIDTH-1:0] rem_next;
  logic [WIDTH-1:0]   q_mag, r_mag, q_final, r_final;
  logic               neg_q, neg_r;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // still the correct unsigned magnitude.
  always_comb begin
    a_neg = signed_divE & src_aE[WIDTH-1];
    b_neg = signed_divE & src_bE[WIDTH-1];
    a_abs = a_neg ? -src_aE : src_aE;
    b_abs = b_neg ? -src_bE : src_bE;
    by_zero = (src_bE == '0);
  end

  // One restoring step on the (2*WIDTH+1)-bit shifted partial remainder.
  always_comb begin
    partial  = {rem, 1'b0};
    upper    = partial[2*WIDTH:WIDTH];
    fits     = (upper >= {1'b0, divisor_abs});
    diff     = upper[WIDTH-1:0] - divisor_abs;
    rem_next = fits ? {diff, partial[WIDTH-1:1], 1'b1} : partial[2*WIDTH-1:0];
    q_mag    = rem_next[WIDTH-1:0];
    r_mag    = rem_next[2*WIDTH-1:WIDTH];
    neg_q    = signed_q & (a_sign_q ^ b_sign_q);
    neg_r    = signed_q & a_sign_q;
    q_final  = neg_q ? -q_mag : q_mag;
    r_final  = neg_r ? -r_mag : r_mag;
  end

  assign last_step = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall_c = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (startE) begin
          accept  = 1'b1;
          stall_c = 1'b1;
          state_d = by_zero ? DONE : CALC;
        end
      end
      CALC: begin
        stall_c = 1'b1;
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush wins over everything, including a start in the same cycle
    if (flushE) begin
      state_d = IDLE;
      accept  = 1'b0;
      stall_c = 1'b0;
      ready_c = 1'b0;
    end
    if (!rst) begin
      accept  = 1'b0;
      stall_c = 1'b0;
      ready_c = 1'b0;
    end
  end

  assign div_stallE = stall_c;
  assign div_readyE = ready_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count       <= '0;
      rem         <= '0;
      divisor_abs <= '0;
      signed_q    <= 1'b0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      div_resultE <= '0;
    end else if (accept) begin
      count       <= '0;
      rem         <= {{WIDTH{1'b0}}, a_abs};
      divisor_abs <= b_abs;
      signed_q    <= signed_divE;
      a_sign_q    <= src_aE[WIDTH-1];
      b_sign_q    <= src_bE[WIDTH-1];
      if (by_zero) begin
        div_resultE <= {src_aE, {WIDTH{1'b1}}};
      end
    end else if (state_q == CALC && !flushE) begin
      rem   <= rem_next;
      count <= count + CW'(1);
      if (last_step) begin
        div_resultE <= {r_final, q_final};
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter: vectors, random vs model, corner sequences
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_aE, src_bE;
  logic        signed_divE, startE, flushE;
  logic        div_stallE, div_readyE;
  logic [63:0] div_resultE;

  int n_checks = 0;
  int n_fail   = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .src_aE(src_aE), .src_bE(src_bE),
    .signed_divE(signed_divE), .startE(startE), .flushE(flushE),
    .div_stallE(div_stallE), .div_readyE(div_readyE), .div_resultE(div_resultE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Called just after a rising edge; leaves off just after the edge that ends the DONE cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic hold, input logic [63:0] exp, input string name);
    int cyc, lat, stall_cnt, lat_exp;
    logic got, stall_at_ready;
    logic [63:0] res;
    lat_exp = (b == 32'd0) ? 1 : 33;
    src_aE = a; src_bE = b; signed_divE = s; startE = 1'b1;
    @(negedge clk);
    check({name, "_stall_start"}, 64'(div_stallE), 64'd1);
    @(posedge clk); #1;
    if (!hold) startE = 1'b0;
    cyc = 1; got = 1'b0; lat = 999; stall_cnt = 0; stall_at_ready = 1'b1; res = '0;
    while (cyc < 45 && !got) begin
      @(negedge clk);
      if (div_readyE) begin
        got = 1'b1; lat = cyc; res = div_resultE; stall_at_ready = div_stallE;
        startE = 1'b0;
      end else begin
        if (div_stallE) stall_cnt++;
        cyc++;
      end
      @(posedge clk); #1;
    end
    check({name, "_latency"}, 64'(lat), 64'(lat_exp));
    check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(lat_exp - 1));
    check({name, "_stall_ready"}, 64'(stall_at_ready), 64'd0);
    check({name, "_result"}, res, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] last_res;
    int          pulses;

    vecs[0] = '{32'd100,        32'd7,          1'b0, {32'h0000_0002, 32'h0000_000E}};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD}};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0000_0000, 32'h8000_0000}};
    vecs[4] = '{32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0000_0000, 32'hFFFF_FFFF}};
    vecs[5] = '{32'h0000_1234,  32'd0,          1'b0, {32'h0000_1234, 32'hFFFF_FFFF}};
    vecs[6] = '{32'hFFFF_FFF9,  32'd2,          1'b0, {32'h0000_0001, 32'h7FFF_FFFC}};
    vecs[7] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, {32'hFFFF_FFFE, 32'h0000_000E}};
    vecs[8] = '{32'hFFFF_FFFB,  32'd0,          1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
    vecs[9] = '{32'd0,          32'd5,          1'b1, {32'h0000_0000, 32'h0000_0000}};

    rst = 1'b0; src_aE = '0; src_bE = '0; signed_divE = 1'b0; startE = 1'b0; flushE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_stall", 64'(div_stallE), 64'd0);
    check("reset_ready", 64'(div_readyE), 64'd0);
    check("reset_result", div_resultE, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      rs = 1'($urandom_range(0, 1));
      do_div(ra, rb, rs, 1'b0, model(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    // Flush in cycle 10 of a CALC, restart in cycle 12 completes in cycle 45.
    do_div(32'd50, 32'd6, 1'b0, 1'b0, model(32'd50, 32'd6, 1'b0), "pre_flush");
    last_res = model(32'd50, 32'd6, 1'b0);
    src_aE = 32'd1000; src_bE = 32'd3; signed_divE = 1'b0; startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flushE = 1'b1;
    @(negedge clk);
    check("flush_stall_c10", 64'(div_stallE), 64'd0);
    check("flush_ready_c10", 64'(div_readyE), 64'd0);
    @(posedge clk); #1;
    flushE = 1'b0;
    @(negedge clk);
    check("flush_stall_c11", 64'(div_stallE), 64'd0);
    check("flush_ready_c11", 64'(div_readyE), 64'd0);
    check("flush_result_held", div_resultE, last_res);
    @(posedge clk); #1;
    do_div(32'd1000, 32'd3, 1'b0, 1'b0, {32'd1, 32'd333}, "after_flush");

    // Reset asserted in cycle 5 of a CALC.
    src_aE = 32'd999; src_bE = 32'd4; signed_divE = 1'b0; startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midreset_stall", 64'(div_stallE), 64'd0);
    check("midreset_ready", 64'(div_readyE), 64'd0);
    check("midreset_result", div_resultE, 64'd0);
    @(posedge clk); #1;
    do_div(32'hFFFF_FF00, 32'd16, 1'b1, 1'b0, model(32'hFFFF_FF00, 32'd16, 1'b1), "post_reset");

    // startE held through CALC: single pulse, no restart.
    do_div(32'd12345, 32'd10, 1'b0, 1'b1, {32'd5, 32'd1234}, "held_start");
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_readyE) pulses++;
    end
    check("held_start_extra_pulses", 64'(pulses), 64'd0);
    check("held_start_result_stable", div_resultE, {32'd5, 32'd1234});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; quotient and remainder are each WIDTH bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port src_aE, input, WIDTH: dividend, Execute stage.
REQ-005 SHALL have port src_bE, input, WIDTH: divisor, Execute stage.
REQ-006 SHALL have port signed_divE, input, 1: 1 selects DIV (signed); 0 selects DIVU.
REQ-007 SHALL have port startE, input, 1: request a division using the current operands.
REQ-008 SHALL have port flushE, input, 1: abort any operation in progress.
REQ-009 SHALL have port div_stallE, output, 1: holds the pipeline at Execute while the division is busy.
REQ-010 SHALL have port div_readyE, output, 1: one-cycle pulse; div_resultE is valid.
REQ-011 SHALL have port div_resultE, output, 2*WIDTH: {remainder, quotient}, written into HI/LO and later read back by the ALU's MFHI/MFLO.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL, in IDLE with startE=1 and flushE=0, latch absolute-valued operands, sign flags and signed_divE, and go to CALC with iteration counter = 0.
REQ-014 SHALL ignore startE in CALC and DONE.
REQ-015 SHALL perform one restoring shift-subtract step per CALC cycle over a (2*WIDTH+1)-bit partial remainder, for exactly WIDTH cycles, then enter DONE.
REQ-016 SHALL, in DONE, drive div_readyE=1 for exactly one cycle and return to IDLE on the next edge.
REQ-017 SHALL give fixed latency: start accepted in cycle N -> div_readyE=1 in cycle N+WIDTH+1 (N+33 for WIDTH=32).
REQ-018 SHALL drive div_stallE = (IDLE and startE and not flushE) or CALC; div_stallE=0 in DONE so the pipeline advances in the same cycle the result is taken.
REQ-019 SHALL, for signed mode, negate the quotient when the operand signs differ and give the remainder the dividend's sign; for unsigned mode apply no sign correction.
REQ-020 SHALL return, for signed 0x80000000 / 0xFFFFFFFF, quotient 0x80000000 and remainder 0, with no overflow flag.
REQ-021 SHALL detect divisor=0 at acceptance, skip CALC, and enter DONE in cycle N+1 with quotient all ones and remainder = the raw dividend.
REQ-022 SHALL hold div_resultE stable from DONE until the next accepted start.
REQ-023 SHALL, on flushE=1 in any state, go to IDLE on the next edge with no div_readyE pulse and div_stallE=0 in that cycle; flush has priority over start.

Reset
REQ-024 SHALL, when rst=0 at a clock edge, set state=IDLE, counter=0, div_resultE=0, div_readyE=0 and div_stallE=0, including during CALC.
REQ-025 SHALL accept a new start on the first cycle after rst returns high.

Structure
REQ-026 SHALL place the FSM state enum and the DIV/DIVU alucontrol codes in the shared defines package used by the ALU and the decoder.
REQ-027 SHALL be one flat module; sign correction and the iteration step are local logic, and no sub-module is required.

Verification
REQ-028 SHALL check DIVU 100/7 started in cycle 0 -> div_readyE in cycle 33, result {0x00000002, 0x0000000E}, div_stallE high in cycles 0-32.
REQ-029 SHALL check DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-030 SHALL check DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}; DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
REQ-031 SHALL check divide by zero, dividend 0x1234 -> div_readyE in cycle 1, result {0x00001234, 0xFFFFFFFF}.
REQ-032 SHALL check flushE in cycle 10 of a CALC -> no div_readyE, div_stallE=0 from cycle 10; a start in cycle 12 then completes in cycle 45.
REQ-033 SHALL check rst=0 in cycle 5 of a CALC -> all outputs 0 next cycle; startE held high during CALC -> no restart and only one div_readyE pulse.
